// File: rtl/btn_conditioner_if.sv
// Button conditioner port bundle: raw buttons and frame tick in, clean levels and pulses out.
interface btn_conditioner_if #(
  parameter int unsigned N_BTN = 4
);
  logic [N_BTN-1:0] btn_raw;
  logic             frame_end;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] press_pulse;
  logic [N_BTN-1:0] release_pulse;
  logic [N_BTN-1:0] repeat_pulse;
  logic [N_BTN-1:0] step_pulse;

  // Stimulus / consumer side
  modport master (
    output btn_raw,
    output frame_end,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  repeat_pulse,
    input  step_pulse
  );

  // Conditioner side
  modport slave (
    input  btn_raw,
    input  frame_end,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output repeat_pulse,
    output step_pulse
  );
endinterface

// File: rtl/btn_conditioner.sv
// Per-button synchronizer, debouncer, edge detector and frame-locked auto-repeat.
// Every output is a flop; downstream logic sees one-cycle pulses only.
module btn_conditioner #(
  parameter int unsigned N_BTN               = 4,
  parameter int unsigned SYNC_STAGES         = 2,
  parameter int unsigned DEBOUNCE_CYCLES     = 250000,
  parameter int unsigned REPEAT_DELAY_FRAMES = 30,
  parameter int unsigned REPEAT_RATE_FRAMES  = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  btn_conditioner_if.slave bus
);

  localparam int unsigned DB_W       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned MAX_FRAMES = (REPEAT_DELAY_FRAMES > REPEAT_RATE_FRAMES) ?
                                       REPEAT_DELAY_FRAMES : REPEAT_RATE_FRAMES;
  localparam int unsigned FR_W       = $clog2(MAX_FRAMES + 1);

  // Terminal values: the cycle/frame that reaches the target count is the one that fires.
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FR_W-1:0] DELAY_LAST = FR_W'(REPEAT_DELAY_FRAMES - 1);
  localparam logic [FR_W-1:0] RATE_LAST  = FR_W'(REPEAT_RATE_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_t;

  logic [N_BTN-1:0]            sync_q [SYNC_STAGES];
  logic [N_BTN-1:0][DB_W-1:0]  db_cnt_q;
  logic [N_BTN-1:0][FR_W-1:0]  fr_cnt_q;
  rpt_state_t                  state_q [N_BTN];

  logic [N_BTN-1:0] level_q;
  logic [N_BTN-1:0] press_q;
  logic [N_BTN-1:0] release_q;
  logic [N_BTN-1:0] repeat_q;
  logic [N_BTN-1:0] step_q;

  logic [N_BTN-1:0] sync_c;
  logic [N_BTN-1:0] accept_c;
  logic [N_BTN-1:0] press_c;
  logic [N_BTN-1:0] release_c;
  logic [N_BTN-1:0] fire_c;

  // Metastability chain: raw pins shift through SYNC_STAGES flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= bus.btn_raw;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // Decode acceptance, edge direction and repeat firing for every channel.
  always_comb begin
    sync_c    = sync_q[SYNC_STAGES-1];
    accept_c  = '0;
    press_c   = '0;
    release_c = '0;
    fire_c    = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      accept_c[i]  = (sync_c[i] != level_q[i]) && (db_cnt_q[i] == DB_LAST);
      press_c[i]   = accept_c[i] & ~level_q[i];
      release_c[i] = accept_c[i] &  level_q[i];
      // A release always wins over a coinciding qualifying frame.
      unique case (state_q[i])
        ST_HOLD:   fire_c[i] = bus.frame_end && !release_c[i] && (fr_cnt_q[i] == DELAY_LAST);
        ST_REPEAT: fire_c[i] = bus.frame_end && !release_c[i] && (fr_cnt_q[i] == RATE_LAST);
        default:   fire_c[i] = 1'b0;
      endcase
    end
  end

  // Debounce counters, accepted level and all registered pulse outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      db_cnt_q  <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
      step_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
        if ((sync_c[i] == level_q[i]) || accept_c[i]) begin
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
        end
      end
      level_q   <= level_q ^ accept_c;
      press_q   <= press_c;
      release_q <= release_c;
      repeat_q  <= fire_c;
      step_q    <= press_c | fire_c;
    end
  end

  // Per-channel repeat FSM; frame_end in the press cycle is ignored because IDLE does not count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fr_cnt_q <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        state_q[i] <= ST_IDLE;
      end
    end else begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
        unique case (state_q[i])
          ST_IDLE: begin
            if (press_c[i]) begin
              state_q[i]  <= ST_HOLD;
              fr_cnt_q[i] <= '0;
            end
          end
          ST_HOLD, ST_REPEAT: begin
            if (release_c[i]) begin
              state_q[i]  <= ST_IDLE;
              fr_cnt_q[i] <= '0;
            end else if (fire_c[i]) begin
              state_q[i]  <= ST_REPEAT;
              fr_cnt_q[i] <= '0;
            end else if (bus.frame_end) begin
              fr_cnt_q[i] <= fr_cnt_q[i] + FR_W'(1);
            end
          end
          default: begin
            state_q[i]  <= ST_IDLE;
            fr_cnt_q[i] <= '0;
          end
        endcase
      end
    end
  end

  assign bus.btn_level     = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.repeat_pulse  = repeat_q;
  assign bus.step_pulse    = step_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: predicted pulses are queued with their cycle and
// compared when the monitor reaches that cycle; any pulse without a prediction is an error.
module tb_btn_conditioner;

  localparam int unsigned N_BTN        = 4;
  localparam int unsigned SYNC         = 2;
  localparam int unsigned DEB          = 4;
  localparam int unsigned RD           = 3;
  localparam int unsigned RR           = 2;
  localparam int          FRAME_PERIOD = 20;
  localparam int          LAT          = SYNC + DEB;

  typedef enum int {EV_PRESS, EV_RELEASE, EV_REPEAT} ev_kind_t;
  typedef struct {
    int       cyc;
    ev_kind_t kind;
    int       ch;
  } ev_t;

  logic clock = 1'b0;
  logic reset_n;

  btn_conditioner_if #(.N_BTN(N_BTN)) bus ();

  btn_conditioner #(
    .N_BTN              (N_BTN),
    .SYNC_STAGES        (SYNC),
    .DEBOUNCE_CYCLES    (DEB),
    .REPEAT_DELAY_FRAMES(RD),
    .REPEAT_RATE_FRAMES (RR)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int               cyc = 0;
  int               n_checks = 0;
  int               n_errors = 0;
  ev_t              exp_q[$];
  logic [N_BTN-1:0] exp_level = '0;
  int               rep_seen[N_BTN];

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic void push_ev(input int c, input ev_kind_t k, input int ch);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    e.ch   = ch;
    exp_q.push_back(e);
  endfunction

  // frame_end is high in the cycle after edges n with n % FRAME_PERIOD == 0,
  // so it is sampled by the DUT at edges F with F % FRAME_PERIOD == 1.
  function automatic int next_frame(input int x);
    int f;
    f = x + 1;
    while ((f % FRAME_PERIOD) != 1) f++;
    return f;
  endfunction

  // Predict press at p, release at rel (<=0: still held), repeats on the RD-th frame
  // after the press and every RR-th thereafter, strictly before the release cycle.
  function automatic void expect_hold(input int ch, input int p, input int rel);
    int lim;
    int k;
    lim = (rel > 0) ? rel : p + 1000;
    push_ev(p, EV_PRESS, ch);
    if (rel > 0) push_ev(rel, EV_RELEASE, ch);
    k = 0;
    for (int f = next_frame(p); f < lim; f += FRAME_PERIOD) begin
      k++;
      if ((k == RD) || ((k > RD) && (((k - RD) % RR) == 0))) push_ev(f, EV_REPEAT, ch);
    end
  endfunction

  // Cycle counter and frame tick generator.
  initial begin
    bus.frame_end = 1'b0;
    forever begin
      @(posedge clock);
      cyc++;
      #1;
      bus.frame_end = ((cyc % FRAME_PERIOD) == 0);
    end
  end

  // Output monitor: retire predictions due this cycle and compare against the DUT.
  always @(negedge clock) begin : monitor
    logic [N_BTN-1:0] ep, er, et, obs;
    if (reset_n !== 1'b1) begin
      check_eq("reset_outputs", 32'({bus.btn_level, bus.press_pulse, bus.release_pulse,
                                     bus.repeat_pulse, bus.step_pulse}), 32'd0);
    end else begin
      ep = '0;
      er = '0;
      et = '0;
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].cyc <= cyc) begin
          if (exp_q[i].cyc < cyc) begin
            check_eq("late_event", 32'(cyc), 32'(exp_q[i].cyc));
          end else begin
            case (exp_q[i].kind)
              EV_PRESS:   ep[exp_q[i].ch] = 1'b1;
              EV_RELEASE: er[exp_q[i].ch] = 1'b1;
              EV_REPEAT:  et[exp_q[i].ch] = 1'b1;
              default:    ;
            endcase
          end
          exp_q.delete(i);
        end
      end
      exp_level = (exp_level | ep) & ~er;
      obs = bus.press_pulse | bus.release_pulse | bus.repeat_pulse | bus.step_pulse;
      if ((ep | er | et | obs) != '0) begin
        check_eq("press_pulse",   32'(bus.press_pulse),   32'(ep));
        check_eq("release_pulse", 32'(bus.release_pulse), 32'(er));
        check_eq("repeat_pulse",  32'(bus.repeat_pulse),  32'(et));
        check_eq("step_pulse",    32'(bus.step_pulse),    32'(ep | et));
      end
      check_eq("btn_level", 32'(bus.btn_level), 32'(exp_level));
      for (int c = 0; c < int'(N_BTN); c++) begin
        if (bus.repeat_pulse[c]) rep_seen[c]++;
      end
    end
  end

  // Press the channels in mask together, hold for 'hold' cycles, release together.
  task automatic hold_press(input logic [N_BTN-1:0] mask, input int hold);
    int r;
    r = cyc;
    for (int c = 0; c < int'(N_BTN); c++) begin
      if (mask[c]) expect_hold(c, r + LAT, r + hold + LAT);
    end
    bus.btn_raw = bus.btn_raw | mask;
    repeat (hold) step();
    bus.btn_raw = bus.btn_raw & ~mask;
    repeat (LAT + 4) step();
  endtask

  // Arrange the accepted release to land on the nth qualifying frame after the press.
  task automatic release_on_frame(input int ch, input int nth, input int exp_reps);
    int p;
    int rel;
    int base;
    p    = cyc + LAT;
    rel  = next_frame(p) + (nth - 1) * FRAME_PERIOD;
    base = rep_seen[ch];
    expect_hold(ch, p, rel);
    bus.btn_raw[ch] = 1'b1;
    while (cyc < rel - LAT) step();
    bus.btn_raw[ch] = 1'b0;
    repeat (LAT + 4) step();
    check_eq("rel_on_frame_reps", 32'(rep_seen[ch] - base), 32'(exp_reps));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int base;
    int r2;
    for (int c = 0; c < int'(N_BTN); c++) rep_seen[c] = 0;
    bus.btn_raw = '0;
    reset_n     = 1'b0;
    repeat (3) step();
    check_eq("rst_level",   32'(bus.btn_level),   32'd0);
    check_eq("rst_press",   32'(bus.press_pulse), 32'd0);
    check_eq("rst_step",    32'(bus.step_pulse),  32'd0);
    reset_n = 1'b1;
    repeat (5) step();

    // Clean press and release on channel 0.
    hold_press(4'b0001, 30);

    // Three-cycle glitch on channel 1 must be invisible.
    bus.btn_raw[1] = 1'b1;
    repeat (3) step();
    bus.btn_raw[1] = 1'b0;
    repeat (12) step();
    check_eq("glitch_level", 32'(bus.btn_level), 32'd0);

    // Ten-frame hold on channel 2: repeats on frames 3, 5, 7, 9.
    base = rep_seen[2];
    hold_press(4'b0100, 200);
    check_eq("autorep_count", 32'(rep_seen[2] - base), 32'd4);

    // Release coinciding with the first-repeat frame, then with a rate frame.
    release_on_frame(0, 3, 0);
    release_on_frame(3, 5, 1);

    // Simultaneous presses on 0 and 3 with different hold lengths.
    begin
      int r;
      r = cyc;
      expect_hold(0, r + LAT, r + 100 + LAT);
      expect_hold(3, r + LAT, r + 180 + LAT);
      bus.btn_raw = bus.btn_raw | 4'b1001;
      repeat (100) step();
      bus.btn_raw[0] = 1'b0;
      repeat (80) step();
      bus.btn_raw[3] = 1'b0;
      repeat (LAT + 4) step();
    end

    // Reset while channel 2 repeats and channel 0 is mid-debounce.
    begin
      int r;
      r = cyc;
      expect_hold(2, r + LAT, 0);
      bus.btn_raw[2] = 1'b1;
      repeat (110) step();
      bus.btn_raw[0] = 1'b1;
      repeat (3) step();
      #2;
      reset_n = 1'b0;
      exp_q.delete();
      exp_level = '0;
      #1;
      check_eq("async_rst_level",  32'(bus.btn_level),     32'd0);
      check_eq("async_rst_press",  32'(bus.press_pulse),   32'd0);
      check_eq("async_rst_rel",    32'(bus.release_pulse), 32'd0);
      check_eq("async_rst_repeat", 32'(bus.repeat_pulse),  32'd0);
      check_eq("async_rst_step",   32'(bus.step_pulse),    32'd0);
      repeat (2) step();
      reset_n = 1'b1;
      r2 = cyc;
      expect_hold(0, r2 + LAT, r2 + 100 + LAT);
      expect_hold(2, r2 + LAT, r2 + 100 + LAT);
      repeat (100) step();
      bus.btn_raw = bus.btn_raw & ~4'b0101;
      repeat (LAT + 4) step();
    end

    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
